// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int N_PORT_DEF = 4;
  localparam int ADDR_W_DEF = 23;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/sdram_arbiter_picker.sv
// Combinational winner selection: first pending port at or after 'start',
// scanning upward and wrapping past N_PORT-1 back to port 0.
module arb_picker #(
  parameter int N_PORT = 4,
  parameter int GW     = 2
) (
  input  logic [N_PORT-1:0] pending,
  input  logic [GW-1:0]     start,
  output logic [GW-1:0]     winner,
  output logic              any
);

  // Scan from the farthest offset down to offset 0 so the port closest to
  // 'start' is the last one to overwrite the result.
  always_comb begin
    int idx;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int i = N_PORT - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N_PORT) idx = idx - N_PORT;
      if (pending[idx]) begin
        winner = GW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Multi-port arbiter in front of an Avalon-style SDRAM controller.
// One transfer in flight at a time; each requester gets a one-cycle
// req_finished pulse when its transfer completes.
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration starting
// after the last granted port; otherwise fixed priority with port 0 highest.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no transfer; pick a winner among pending ports and latch it
// ISSUE     | command on the SDRAM bus, held while sd_waitrequest is high
// WAIT_DATA | read accepted, waiting for sd_readdatavalid
// DONE      | pulse req_finished for the granted port, requests ignored
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int N_PORT = N_PORT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int GW    = (N_PORT > 1) ? $clog2(N_PORT) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_PORT-1:0]          req_read,
  input  logic [N_PORT-1:0]          req_write,
  input  logic [N_PORT*ADDR_W-1:0]   req_addr,
  input  logic [N_PORT*DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]          req_readdata,
  output logic [N_PORT-1:0]          req_finished,
  output logic [ADDR_W-1:0]          sd_address,
  output logic                       sd_read,
  output logic                       sd_write,
  output logic [DATA_W-1:0]          sd_writedata,
  input  logic [DATA_W-1:0]          sd_readdata,
  input  logic                       sd_readdatavalid,
  input  logic                       sd_waitrequest,
  output logic [GW-1:0]              o_grant
);

  state_t              state;
  state_t              state_nxt;
  logic [GW-1:0]       grant;
  logic                op_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [N_PORT-1:0]   pending;
  logic [N_PORT-1:0]   grant_onehot;
  logic [GW-1:0]       pick_start;
  logic [GW-1:0]       winner;
  logic                any_pending;

  assign pending      = req_read | req_write;
  assign grant_onehot = {{(N_PORT-1){1'b0}}, 1'b1} << grant;

`ifdef SDRAM_ARB_RR_EN
  // Resume the search just after the port served last.
  assign pick_start = (grant == GW'(N_PORT - 1)) ? '0 : grant + GW'(1);
`else
  assign pick_start = '0;
`endif

  arb_picker #(
    .N_PORT (N_PORT),
    .GW     (GW)
  ) u_picker (
    .pending (pending),
    .start   (pick_start),
    .winner  (winner),
    .any     (any_pending)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and bus/handshake outputs.
  always_comb begin
    state_nxt    = state;
    sd_read      = 1'b0;
    sd_write     = 1'b0;
    req_finished = '0;
    case (state)
      IDLE: begin
        if (any_pending) state_nxt = ISSUE;
      end
      ISSUE: begin
        sd_read  = ~op_write;
        sd_write = op_write;
        if (!sd_waitrequest) state_nxt = op_write ? DONE : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (sd_readdatavalid) state_nxt = DONE;
      end
      DONE: begin
        req_finished = grant_onehot;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winning request in IDLE and capture read data in WAIT_DATA;
  // a readdatavalid arriving in any other state is ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant    <= GW'(N_PORT - 1);
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && any_pending) begin
        grant    <= winner;
        op_write <= req_write[winner];
        addr_q   <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        wdata_q  <= req_writedata[int'(winner)*DATA_W +: DATA_W];
      end
      if (state == WAIT_DATA && sd_readdatavalid) rdata_q <= sd_readdata;
    end
  end

  assign sd_address   = addr_q;
  assign sd_writedata = wdata_q;
  assign req_readdata = rdata_q;
  assign o_grant      = grant;

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
- REQ-001 SHALL have parameter N_PORT, default 4, meaning number of requesters (mix, record, play, load).
- REQ-002 SHALL have parameter ADDR_W, default 23, meaning SDRAM word address width.
- REQ-003 SHALL have parameter DATA_W, default 32, meaning SDRAM word width.
- REQ-004 SHALL have port i_clk, input, 1, system clock.
- REQ-005 SHALL have port i_rst, input, 1, reset (asynchronous, active-high).
- REQ-006 SHALL have port req_read, input, N_PORT, per-port read request.
- REQ-007 SHALL have port req_write, input, N_PORT, per-port write request.
- REQ-008 SHALL have port req_addr, input, N_PORT x ADDR_W, per-port address.
- REQ-009 SHALL have port req_writedata, input, N_PORT x DATA_W, per-port write data.
- REQ-010 SHALL have port req_readdata, output, DATA_W, shared registered read data.
- REQ-011 SHALL have port req_finished, output, N_PORT, one-hot completion pulse.
- REQ-012 SHALL have port sd_address, output, ADDR_W, SDRAM controller address.
- REQ-013 SHALL have port sd_read / sd_write, output, 1 each, SDRAM commands.
- REQ-014 SHALL have port sd_writedata, output, DATA_W, SDRAM write data.
- REQ-015 SHALL have port sd_readdata, input, DATA_W, SDRAM read data.
- REQ-016 SHALL have port sd_readdatavalid / sd_waitrequest, input, 1 each, SDRAM handshake.
- REQ-017 SHALL have port o_grant, output, clog2(N_PORT), currently or last granted port (debug).

Function
- REQ-018 SHALL implement states IDLE, ISSUE, WAIT_DATA, DONE.
- REQ-019 IDLE: port pending if req_read|req_write; on any pending, SHALL latch winner index, address, writedata, op (write wins if both set) and go ISSUE; else stay.
- REQ-020 ISSUE: SHALL drive sd_read or sd_write with latched address/data, held stable while sd_waitrequest=1; on accept, write -> DONE, read -> WAIT_DATA.
- REQ-021 WAIT_DATA: on sd_readdatavalid SHALL register sd_readdata into req_readdata and go DONE; no timeout.
- REQ-022 DONE: SHALL assert req_finished[grant] for exactly one cycle, then IDLE; requests are ignored in DONE.
- REQ-023 Latency: request sampled at edge k with no waitrequest gives write finished during cycle k+2; read finished one cycle after readdatavalid.
- REQ-024 req_readdata SHALL hold its value until the next completed read.
- REQ-025 A requester dropping its request mid-transaction SHALL NOT abort it; finished still pulses.
- REQ-026 Requests are level; a request still high in the cycle after finished SHALL be treated as a new transaction.
- REQ-027 At most one sd_read/sd_write SHALL be outstanding; both never high together.

Reset
- REQ-028 i_rst SHALL force IDLE; sd_read=sd_write=0, sd_address=0, sd_writedata=0, req_readdata=0, req_finished=0, o_grant=N_PORT-1, mid-transaction included; in-flight transfer is dropped and a late readdatavalid in IDLE ignored.

Configuration
- REQ-029 With SDRAM_ARB_RR_EN defined, SHALL arbitrate round-robin starting at o_grant+1 (wrapping N_PORT-1 -> 0).
- REQ-030 Without SDRAM_ARB_RR_EN, SHALL use fixed priority, port 0 highest.

Structure
- REQ-031 Package sdram_arb_pkg SHALL hold the state enum and default N_PORT/ADDR_W/DATA_W constants.
- REQ-032 Combinational sub-module arb_picker SHALL compute winner from pending vector and start pointer.

Verification
- REQ-033 Port 1 write addr 0x000010 data 0xDEADBEEF, no waitrequest -> sd_write one cycle, req_finished=0b0010 at k+2.
- REQ-034 Port 0 read addr 0x7FFFFF, readdatavalid 3 cycles after accept data 0x12345678 -> req_readdata=0x12345678, req_finished=0b0001.
- REQ-035 All 4 ports requesting continuously, RR_EN -> grant order 0,1,2,3,0; without -> port 0 only.
- REQ-036 sd_waitrequest high 5 cycles during ISSUE -> address/command stable, single accept, one finished pulse.
- REQ-037 i_rst asserted in WAIT_DATA -> all outputs reset next edge; following readdatavalid causes no finished.
